// File: rtl/ex2_wb_pkg.sv
// ex2_wb_pkg: lane-0 M-op encoding, divider FSM states and shared helpers for the EX2 stage.
package ex2_wb_pkg;

    localparam int DIV_ITERS = 32;

    typedef enum logic [2:0] {
        OP_NONE  = 3'd0,
        OP_MUL   = 3'd1,
        OP_MULH  = 3'd2,
        OP_MULHU = 3'd3,
        OP_DIV   = 3'd4,
        OP_MOD   = 3'd5,
        OP_DIVU  = 3'd6,
        OP_MODU  = 3'd7
    } op_e;

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} div_state_e;

    function automatic logic is_div(op_e op);
        return op[2];
    endfunction

    function automatic logic is_mul(op_e op);
        return op inside {OP_MUL, OP_MULH, OP_MULHU};
    endfunction

    function automatic logic [31:0] mag(logic [31:0] x, logic s);
        return (s && x[31]) ? -x : x;
    endfunction

endpackage

// File: rtl/ex2_wb_if.sv
// ex2_wb_if: EX1/EX2 register contents in, EX2/WB register contents and stall out.
interface ex2_wb_if;
    import ex2_wb_pkg::*;
    logic        flush_in, flush_out, ex2_stall;
    logic        in_valid0, in_valid1, alu_valid0, alu_valid1;
    logic [31:0] pc0, pc1, alu_data0, alu_data1;
    logic [4:0]  rd0, rd1;
    op_e         op0;
    logic [31:0] mul_hh, mul_hl, mul_lh, mul_ll, mul_comp, div_a, div_b;
    logic        ex2_wb_valid0, ex2_wb_valid1;
    logic [31:0] ex2_wb_pc0, ex2_wb_pc1, ex2_wb_data0, ex2_wb_data1;
    logic [4:0]  ex2_wb_rd0, ex2_wb_rd1;

    modport slave (
        input  flush_in, in_valid0, in_valid1, alu_valid0, alu_valid1, pc0, pc1,
               alu_data0, alu_data1, rd0, rd1, op0, mul_hh, mul_hl, mul_lh, mul_ll,
               mul_comp, div_a, div_b,
        output flush_out, ex2_stall, ex2_wb_valid0, ex2_wb_valid1, ex2_wb_pc0,
               ex2_wb_pc1, ex2_wb_data0, ex2_wb_data1, ex2_wb_rd0, ex2_wb_rd1
    );

    modport master (
        output flush_in, in_valid0, in_valid1, alu_valid0, alu_valid1, pc0, pc1,
               alu_data0, alu_data1, rd0, rd1, op0, mul_hh, mul_hl, mul_lh, mul_ll,
               mul_comp, div_a, div_b,
        input  flush_out, ex2_stall, ex2_wb_valid0, ex2_wb_valid1, ex2_wb_pc0,
               ex2_wb_pc1, ex2_wb_data0, ex2_wb_data1, ex2_wb_rd0, ex2_wb_rd1
    );
endinterface

// File: rtl/ex2_wb_div_radix2.sv
// div_radix2: restoring radix-2 divider on magnitudes with signed fix-up,
// divide-by-zero and overflow handling; start is honoured only when idle.
module div_radix2
    import ex2_wb_pkg::*;
#(
    parameter int DIV_ITERS = ex2_wb_pkg::DIV_ITERS
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        is_signed,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        abort,
    output logic        busy,
    output logic        done,
    output logic [31:0] quot,
    output logic [31:0] rem
);
    localparam int CW = $clog2(DIV_ITERS);

    div_state_e  state, state_d;
    logic [CW-1:0] cnt;
    logic [31:0] q, r, bm, a_q;
    logic        neg_q, neg_r, bz;
    logic [32:0] sh;
    logic [33:0] diff;

    always_ff @(posedge clk)
        if (rst) state <= S_IDLE;
        else     state <= state_d;

    always_comb
        state_d = abort                                      ? S_IDLE :
                  (state == S_IDLE && start)                 ? S_BUSY :
                  (state == S_BUSY && cnt == CW'(DIV_ITERS - 1)) ? S_DONE :
                  (state == S_DONE)                          ? S_IDLE : state;

    always_comb begin
        busy = state == S_BUSY;
        done = state == S_DONE;
    end

    // the dividend shifts out of q while quotient bits shift in behind it
    assign sh   = {r, q[31]};
    assign diff = {1'b0, sh} - {2'b0, bm};

    always_ff @(posedge clk)
        if (rst || abort) cnt <= '0;
        else if (state == S_IDLE && start) begin
            cnt   <= '0;
            q     <= mag(a, is_signed);
            r     <= '0;
            bm    <= mag(b, is_signed);
            neg_q <= is_signed & (a[31] ^ b[31]);
            neg_r <= is_signed & a[31];
            bz    <= b == '0;
            a_q   <= a;
        end else if (state == S_BUSY) begin
            cnt <= cnt + 1'b1;
            q   <= {q[30:0], ~diff[33]};
            r   <= diff[33] ? sh[31:0] : diff[31:0];
        end

    assign quot = bz ? '1  : neg_q ? -q : q;
    assign rem  = bz ? a_q : neg_r ? -r : r;
endmodule

// File: rtl/ex2_wb.sv
// ex2_wb: final execute stage plus EX2/WB register; lane 0 adds multiply combine and
// an iterative divide that stalls upstream, lane 1 is ALU passthrough.
module ex2_wb
    import ex2_wb_pkg::*;
#(
    parameter int DIV_ITERS = ex2_wb_pkg::DIV_ITERS
) (
    input logic   clk,
    input logic   rst,
    ex2_wb_if.slave bus
);
    logic        busy, done, req, stall, load;
    logic [31:0] quot, rem, data0;
    logic [63:0] prod;

    assign req           = bus.in_valid0 & is_div(bus.op0);
    assign stall         = ~bus.flush_in & ((~busy & ~done & req) | busy);
    assign load          = ~bus.flush_in & ~stall;
    assign bus.ex2_stall = stall;
    assign bus.flush_out = bus.flush_in;

    div_radix2 #(.DIV_ITERS(DIV_ITERS)) u_div (
        .clk      (clk),
        .rst      (rst),
        .start    (req & ~bus.flush_in),
        .is_signed(~bus.op0[1]),
        .a        (bus.div_a),
        .b        (bus.div_b),
        .abort    (bus.flush_in),
        .busy     (busy),
        .done     (done),
        .quot     (quot),
        .rem      (rem)
    );

    assign prod = {bus.mul_hh, 32'b0} + {16'b0, bus.mul_hl, 16'b0} + {16'b0, bus.mul_lh, 16'b0}
                + {32'b0, bus.mul_ll} + {bus.mul_comp, 32'b0};

    // op0 is held stable by upstream while the divide runs, so it still selects quot/rem in DONE
    assign data0 = done             ? (bus.op0[0] ? rem : quot) :
                   is_mul(bus.op0)  ? (bus.op0 == OP_MUL ? prod[31:0] : prod[63:32]) :
                   bus.alu_data0;

    always_ff @(posedge clk)
        if (rst) begin
            bus.ex2_wb_valid0 <= 1'b0;
            bus.ex2_wb_valid1 <= 1'b0;
            bus.ex2_wb_pc0    <= '0;
            bus.ex2_wb_pc1    <= '0;
            bus.ex2_wb_rd0    <= '0;
            bus.ex2_wb_rd1    <= '0;
            bus.ex2_wb_data0  <= '0;
            bus.ex2_wb_data1  <= '0;
        end else begin
            bus.ex2_wb_valid0 <= load & bus.in_valid0 & (bus.alu_valid0 | bus.op0 != OP_NONE);
            bus.ex2_wb_valid1 <= load & bus.in_valid1 & bus.alu_valid1;
            if (load) begin
                bus.ex2_wb_pc0   <= bus.pc0;
                bus.ex2_wb_pc1   <= bus.pc1;
                bus.ex2_wb_rd0   <= bus.rd0;
                bus.ex2_wb_rd1   <= bus.rd1;
                bus.ex2_wb_data0 <= data0;
                bus.ex2_wb_data1 <= bus.alu_data1;
            end
        end
endmodule

// File: tb/tb_ex2_wb.sv
// tb_ex2_wb: table-driven ALU/multiply vectors plus hand-written divide, flush and reset sequences.
module tb_ex2_wb;
    import ex2_wb_pkg::*;

    typedef struct {
        logic        v0, v1, av0, av1;
        logic [2:0]  op;
        logic [4:0]  rd0, rd1;
        logic [31:0] pc0, a0, a1, hh, hl, lh, ll, comp;
        logic        ev0, ev1;
        logic [31:0] ed0, ed1;
    } vec_t;

    logic clk = 0;
    logic rst = 1;
    int   tests = 0;
    int   fails = 0;
    vec_t tbl[9];

    ex2_wb_if bus();
    ex2_wb dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic clr();
        bus.flush_in = 0; bus.in_valid0 = 0; bus.in_valid1 = 0;
        bus.alu_valid0 = 0; bus.alu_valid1 = 0; bus.pc0 = 0; bus.pc1 = 0;
        bus.alu_data0 = 0; bus.alu_data1 = 0; bus.rd0 = 0; bus.rd1 = 0; bus.op0 = OP_NONE;
        bus.mul_hh = 0; bus.mul_hl = 0; bus.mul_lh = 0; bus.mul_ll = 0; bus.mul_comp = 0;
        bus.div_a = 0; bus.div_b = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_div(input string name, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp);
        int n;
        int bub;
        clr();
        bus.in_valid0 = 1; bus.op0 = op_e'(op); bus.div_a = a; bus.div_b = b;
        bus.in_valid1 = 1; bus.alu_valid1 = 1; bus.alu_data1 = 32'h55; bus.rd1 = 5'd2;
        #1;
        chk({name, " stall at issue"}, 64'(bus.ex2_stall), 64'd1);
        n = 1;
        bub = 0;
        do begin
            tick();
            if (bus.ex2_wb_valid0 | bus.ex2_wb_valid1) bub++;
            if (bus.ex2_stall) n++;
        end while (bus.ex2_stall && n < 100);
        chk({name, " stall cycles"}, 64'(n), 64'd33);
        chk({name, " bubbles during stall"}, 64'(bub), 64'd0);
        tick();
        chk({name, " data0"}, 64'(bus.ex2_wb_data0), 64'(exp));
        chk({name, " valid0/valid1"}, {bus.ex2_wb_valid0, bus.ex2_wb_valid1}, 64'b11);
        chk({name, " lane1 data"}, 64'(bus.ex2_wb_data1), 64'h55);
        clr();
    endtask

    initial begin
        //          v0 v1 av0 av1 op rd0 rd1 pc0        a0           a1       hh hl        lh       ll            comp          ev0 ev1 ed0          ed1
        tbl[0] = '{1, 1, 1, 1, 3'd0, 3,  4,  32'h100, 32'h1234,    32'hABCD, 0, 0,        0,       0,            0,            1, 1, 32'h1234,    32'hABCD};
        tbl[1] = '{1, 1, 0, 0, 3'd1, 5,  6,  32'h104, 32'hDEAD,    32'h9,    0, 0,        0,       6,            0,            1, 0, 32'h6,       32'h9};
        tbl[2] = '{1, 0, 0, 1, 3'd2, 7,  8,  32'h108, 0,           32'h11,   1, 0,        0,       0,            0,            1, 0, 32'h1,       32'h11};
        tbl[3] = '{1, 1, 0, 1, 3'd1, 9,  10, 32'h10C, 0,           32'h22,   0, 1,        0,       0,            0,            1, 1, 32'h10000,   32'h22};
        tbl[4] = '{1, 1, 1, 1, 3'd2, 1,  2,  32'h110, 0,           32'h33,   2, 0,        0,       5,            32'hFFFFFFFF, 1, 1, 32'h1,       32'h33};
        tbl[5] = '{1, 1, 0, 1, 3'd3, 11, 12, 32'h114, 0,           32'h44,   0, 0,        32'h10000, 0,          0,            1, 1, 32'h1,       32'h44};
        tbl[6] = '{0, 1, 1, 1, 3'd0, 13, 14, 32'h118, 32'h55,      32'h66,   0, 0,        0,       0,            0,            0, 1, 32'h55,      32'h66};
        tbl[7] = '{1, 0, 0, 1, 3'd0, 15, 16, 32'h11C, 32'h77,      32'h88,   0, 0,        0,       0,            0,            0, 0, 32'h77,      32'h88};
        tbl[8] = '{1, 1, 0, 1, 3'd1, 17, 18, 32'h120, 0,           32'h99,   0, 32'h10000, 1,      32'hFFFFFFFF, 0,            1, 1, 32'h0000FFFF, 32'h99};

        clr();
        rst = 1;
        repeat (2) @(posedge clk);
        #1;
        rst = 0;
        chk("reset valids", {bus.ex2_wb_valid0, bus.ex2_wb_valid1}, 64'b00);
        chk("reset pcs", {bus.ex2_wb_pc0, bus.ex2_wb_pc1}, 64'h0);
        chk("reset rds", {bus.ex2_wb_rd0, bus.ex2_wb_rd1}, 64'h0);
        chk("reset data", {bus.ex2_wb_data0, bus.ex2_wb_data1}, 64'h0);
        chk("reset stall", 64'(bus.ex2_stall), 64'd0);

        for (int i = 0; i < 9; i++) begin
            clr();
            bus.in_valid0 = tbl[i].v0; bus.in_valid1 = tbl[i].v1;
            bus.alu_valid0 = tbl[i].av0; bus.alu_valid1 = tbl[i].av1;
            bus.op0 = op_e'(tbl[i].op); bus.rd0 = tbl[i].rd0; bus.rd1 = tbl[i].rd1;
            bus.pc0 = tbl[i].pc0; bus.pc1 = tbl[i].pc0 + 32'd4;
            bus.alu_data0 = tbl[i].a0; bus.alu_data1 = tbl[i].a1;
            bus.mul_hh = tbl[i].hh; bus.mul_hl = tbl[i].hl; bus.mul_lh = tbl[i].lh;
            bus.mul_ll = tbl[i].ll; bus.mul_comp = tbl[i].comp;
            #1;
            chk($sformatf("vec%0d stall", i), 64'(bus.ex2_stall), 64'd0);
            tick();
            chk($sformatf("vec%0d valids", i), {bus.ex2_wb_valid0, bus.ex2_wb_valid1}, {tbl[i].ev0, tbl[i].ev1});
            chk($sformatf("vec%0d data0", i), 64'(bus.ex2_wb_data0), 64'(tbl[i].ed0));
            chk($sformatf("vec%0d data1", i), 64'(bus.ex2_wb_data1), 64'(tbl[i].ed1));
            chk($sformatf("vec%0d rds", i), {bus.ex2_wb_rd0, bus.ex2_wb_rd1}, {tbl[i].rd0, tbl[i].rd1});
            chk($sformatf("vec%0d pcs", i), {bus.ex2_wb_pc0, bus.ex2_wb_pc1}, {tbl[i].pc0, tbl[i].pc0 + 32'd4});
        end

        do_div("DIV.W -7/2",        3'd4, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD);
        do_div("MOD.W -7/2",        3'd5, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF);
        do_div("DIV.W 7/-2",        3'd4, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD);
        do_div("MOD.W 7/-2",        3'd5, 32'd7,        32'hFFFFFFFE, 32'd1);
        do_div("DIV.WU 100/7",      3'd6, 32'd100,      32'd7,        32'd14);
        do_div("MOD.WU 100/7",      3'd7, 32'd100,      32'd7,        32'd2);
        do_div("DIV.WU x/0",        3'd6, 32'd1234,     32'd0,        32'hFFFFFFFF);
        do_div("MOD.WU 5/0",        3'd7, 32'd5,        32'd0,        32'd5);
        do_div("DIV.W -9/0",        3'd4, 32'hFFFFFFF7, 32'd0,        32'hFFFFFFFF);
        do_div("DIV.W ovf",         3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000);
        do_div("MOD.W ovf",         3'd5, 32'h80000000, 32'hFFFFFFFF, 32'd0);

        begin : flush_mid_div
            int stray;
            clr();
            bus.in_valid0 = 1; bus.op0 = OP_DIVU; bus.div_a = 32'd100; bus.div_b = 32'd7;
            repeat (10) tick();
            bus.flush_in = 1;
            #1;
            chk("flush stall drops", 64'(bus.ex2_stall), 64'd0);
            chk("flush_out follows", 64'(bus.flush_out), 64'd1);
            tick();
            chk("flush valid0", 64'(bus.ex2_wb_valid0), 64'd0);
            clr();
            bus.in_valid0 = 1; bus.alu_valid0 = 1; bus.alu_data0 = 32'hA5; bus.rd0 = 5'd9;
            #1;
            chk("post-flush stall", 64'(bus.ex2_stall), 64'd0);
            tick();
            chk("post-flush alu data0", 64'(bus.ex2_wb_data0), 64'hA5);
            chk("post-flush alu valid0", 64'(bus.ex2_wb_valid0), 64'd1);
            bus.in_valid1 = 1; bus.alu_valid1 = 1; bus.alu_data0 = 32'h5A; bus.flush_in = 1;
            tick();
            chk("flush kills valids", {bus.ex2_wb_valid0, bus.ex2_wb_valid1}, 64'b00);
            chk("flush holds data0", 64'(bus.ex2_wb_data0), 64'hA5);
            clr();
            stray = 0;
            repeat (40) begin
                tick();
                if (bus.ex2_wb_valid0 | bus.ex2_stall) stray++;
            end
            chk("aborted divide silent", 64'(stray), 64'd0);
        end

        clr();
        bus.in_valid0 = 1; bus.op0 = OP_DIV; bus.div_a = 32'd50; bus.div_b = 32'd5;
        repeat (5) tick();
        rst = 1;
        clr();
        tick();
        rst = 0;
        chk("mid-div reset stall", 64'(bus.ex2_stall), 64'd0);
        chk("mid-div reset outputs", {bus.ex2_wb_valid0, bus.ex2_wb_data0, bus.ex2_wb_rd0}, 64'h0);
        do_div("DIV.W after reset", 3'd4, 32'd50, 32'd5, 32'd10);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
